// File: rtl/mem_bank_scheduler.sv
//==============================================================================
// Module   : mem_bank_scheduler
// Purpose  : Upstream request scheduler for a banked memory wrapper. Host
//            requests (tagged with a bank number) are buffered in a small FIFO
//            and issued one at a time onto the shared addr/wr_rd/wdata lines
//            with a one-hot per-bank valid. One response strobe is returned
//            per completed request.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready/req_wr_rd/req_bank/req_addr/req_wdata : host in
//            resp_valid/resp_bank/resp_rdata/resp_err                  : host out
//            addr/wr_rd/wdata/valid (out), rdata/ready (in)            : banks
// Config   : `define MEM_SCHED_TIMEOUT_EN enables the ISSUE-state watchdog
//            (TIMEOUT_CYCLES); without it ISSUE waits forever, resp_err = 0.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_bank_scheduler #(
    parameter int NUM_MEMS       = 8,
    parameter int DEPTH          = 64,
    parameter int WIDTH          = 8,
    parameter int ADDR_SIZE      = 6,
    parameter int BANK_SEL_W     = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_wr_rd,
    input  logic [BANK_SEL_W-1:0]     req_bank,
    input  logic [ADDR_SIZE-1:0]      req_addr,
    input  logic [WIDTH-1:0]          req_wdata,
    output logic                      resp_valid,
    output logic [BANK_SEL_W-1:0]     resp_bank,
    output logic [WIDTH-1:0]          resp_rdata,
    output logic                      resp_err,
    output logic [ADDR_SIZE-1:0]      addr,
    output logic                      wr_rd,
    output logic [NUM_MEMS*WIDTH-1:0] wdata,
    input  logic [NUM_MEMS*WIDTH-1:0] rdata,
    output logic [NUM_MEMS-1:0]       valid,
    input  logic [NUM_MEMS-1:0]       ready
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // DEPTH is informational only; referenced here so it is not flagged unused.
    logic w_unused_cfg;
    assign w_unused_cfg = (DEPTH != 0) ^ (TIMEOUT_CYCLES != 0);

    //--------------------------------------------------------------------------
    // Request FIFO
    //--------------------------------------------------------------------------
    logic                  r_fifo_wr_rd [FIFO_DEPTH];
    logic [BANK_SEL_W-1:0] r_fifo_bank  [FIFO_DEPTH];
    logic [ADDR_SIZE-1:0]  r_fifo_addr  [FIFO_DEPTH];
    logic [WIDTH-1:0]      r_fifo_wdata [FIFO_DEPTH];

    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Full is judged on the registered count only, so a same-cycle pop never
    // opens a slot for the host.
    assign req_ready = (r_count != c_CNT_W'(FIFO_DEPTH));
    assign w_push    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_wr_rd[r_wptr] <= req_wr_rd;
            r_fifo_bank[r_wptr]  <= req_bank;
            r_fifo_addr[r_wptr]  <= req_addr;
            r_fifo_wdata[r_wptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    logic                  w_head_wr_rd;
    logic [BANK_SEL_W-1:0] w_head_bank;
    logic [ADDR_SIZE-1:0]  w_head_addr;
    logic [WIDTH-1:0]      w_head_wdata;
    logic                  w_head_bad;

    assign w_head_wr_rd = r_fifo_wr_rd[r_rptr];
    assign w_head_bank  = r_fifo_bank[r_rptr];
    assign w_head_addr  = r_fifo_addr[r_rptr];
    assign w_head_wdata = r_fifo_wdata[r_rptr];
    // Bank numbers beyond the last bank complete without touching memory.
    assign w_head_bad   = (32'(w_head_bank) >= 32'(NUM_MEMS));

    //--------------------------------------------------------------------------
    // Issue registers and bank interface
    //--------------------------------------------------------------------------
    logic                  r_wr_rd;
    logic [BANK_SEL_W-1:0] r_bank;
    logic [ADDR_SIZE-1:0]  r_addr;
    logic [WIDTH-1:0]      r_wdata;

    logic [NUM_MEMS-1:0]   w_onehot;
    logic                  w_hs;
    logic [WIDTH-1:0]      w_lane;

    assign w_onehot = NUM_MEMS'(1) << r_bank;
    assign valid    = (r_state == S_ISSUE) ? w_onehot : '0;
    // Masking with the one-hot ignores ready bits of unselected banks.
    assign w_hs     = (r_state == S_ISSUE) && (|(ready & w_onehot));
    assign addr     = r_addr;
    assign wr_rd    = r_wr_rd;
    assign wdata    = {NUM_MEMS{r_wdata}};

    always_comb begin
        w_lane = '0;
        for (int i = 0; i < NUM_MEMS; i++) begin
            if (r_bank == BANK_SEL_W'(i)) w_lane = rdata[i*WIDTH +: WIDTH];
        end
    end

`ifdef MEM_SCHED_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMO_W-1:0] r_tmo;
    logic               w_tmo_hit;

    // Counts ISSUE cycles; the last allowed cycle is TIMEOUT_CYCLES-1.
    assign w_tmo_hit = (r_tmo == c_TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (r_state == S_ISSUE) begin
            r_tmo <= r_tmo + 1'b1;
        end else begin
            r_tmo <= '0;
        end
    end
`endif

    //--------------------------------------------------------------------------
    // FSM next-state / control
    //--------------------------------------------------------------------------
    logic                  w_load;
    logic                  w_resp_fire;
    logic                  w_resp_err;
    logic [BANK_SEL_W-1:0] w_resp_bank;
    logic [WIDTH-1:0]      w_resp_rdata;

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_resp_fire  = 1'b0;
        w_resp_err   = 1'b0;
        w_resp_bank  = r_bank;
        w_resp_rdata = '0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop = 1'b1;
                    if (w_head_bad) begin
                        w_resp_fire = 1'b1;
                        w_resp_bank = w_head_bank;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (w_hs) begin
                    w_resp_fire  = 1'b1;
                    w_resp_rdata = r_wr_rd ? '0 : w_lane;
                    w_state_nxt  = S_IDLE;
                end
`ifdef MEM_SCHED_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_resp_fire = 1'b1;
                    w_resp_err  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // State, issue and response registers
    //--------------------------------------------------------------------------
    logic                  r_resp_valid;
    logic [BANK_SEL_W-1:0] r_resp_bank;
    logic [WIDTH-1:0]      r_resp_rdata;
    logic                  r_resp_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_rd      <= 1'b0;
            r_bank       <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_bank  <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= w_resp_fire;
            if (w_load) begin
                r_wr_rd <= w_head_wr_rd;
                r_bank  <= w_head_bank;
                r_addr  <= w_head_addr;
                r_wdata <= w_head_wdata;
            end
            if (w_resp_fire) begin
                r_resp_bank  <= w_resp_bank;
                r_resp_rdata <= w_resp_rdata;
                r_resp_err   <= w_resp_err;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_bank  = r_resp_bank;
    assign resp_rdata = r_resp_rdata;
`ifdef MEM_SCHED_TIMEOUT_EN
    assign resp_err   = r_resp_err;
`else
    assign resp_err   = 1'b0;
    logic w_unused_err;
    assign w_unused_err = r_resp_err;
`endif

endmodule

`default_nettype wire
